// File: rtl/uncache_mem_bridge.sv
// Uncached LSU-to-bus bridge. It handles one outstanding load or store. It aligns
// requests to 8-byte bus beats, extracts load data, and reports misaligned accesses
// and bus timeouts.
module uncache_mem_bridge #(
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic        clk,
  input  logic        rst,
  // LSU request
  input  logic        req_vld_i,
  output logic        req_rdy_o,
  input  logic        req_write_i,
  input  logic [2:0]  req_size_i,
  input  logic [63:0] req_addr_i,
  input  logic [63:0] req_wdata_i,
  // LSU response
  output logic        resp_vld_o,
  input  logic        resp_rdy_i,
  output logic [63:0] resp_data_o,
  output logic        resp_err_o,
  // Memory bus
  output logic        bus_req_vld_o,
  input  logic        bus_req_rdy_i,
  output logic        bus_we_o,
  output logic [63:0] bus_addr_o,
  output logic [63:0] bus_wdata_o,
  output logic [7:0]  bus_wstrb_o,
  input  logic        bus_rvld_i,
  input  logic [63:0] bus_rdata_i,
  input  logic        bus_bvld_i,
  // Store error report
  output logic        err_o,
  output logic [63:0] err_addr_o
);

  typedef enum logic [1:0] {StIdle, StBreq, StBresp, StUpresp} state_e;

  // Compared one bit wider so a limit of 255 is reachable by an 8-bit count plus one.
  localparam logic [8:0] TimeoutVal = 9'(TIMEOUT_CYCLES);

  state_e      state_q, state_d;
  logic        write_q, write_d;
  logic [1:0]  size_q, size_d;
  logic [63:0] addr_q, addr_d;
  logic [63:0] wdata_q, wdata_d;
  logic [7:0]  cnt_q, cnt_d;
  logic [63:0] rdata_q, rdata_d;
  logic        rerr_q, rerr_d;
  logic        err_q, err_d;
  logic [63:0] err_addr_q, err_addr_d;

  logic        misaligned;
  logic [2:0]  offset;
  logic [7:0]  strb_base;
  logic [63:0] load_mask;
  logic [63:0] load_data;
  logic [8:0]  cnt_inc;
  logic        timeout;

  // Size bit 2 is not part of the encoding.
  logic unused_size_msb;
  assign unused_size_msb = req_size_i[2];

  assign offset  = addr_q[2:0];
  assign cnt_inc = {1'b0, cnt_q} + 9'd1;
  assign timeout = (cnt_inc == TimeoutVal);

  // Alignment check on the incoming request.
  always_comb begin
    misaligned = 1'b0;
    unique case (req_size_i[1:0])
      2'd0:    misaligned = 1'b0;
      2'd1:    misaligned = req_addr_i[0];
      2'd2:    misaligned = |req_addr_i[1:0];
      default: misaligned = |req_addr_i[2:0];
    endcase
  end

  // Byte-strobe pattern and load mask for the latched access size.
  always_comb begin
    strb_base = 8'h00;
    load_mask = '0;
    unique case (size_q)
      2'd0: begin
        strb_base = 8'h01;
        load_mask = 64'h0000_0000_0000_00ff;
      end
      2'd1: begin
        strb_base = 8'h03;
        load_mask = 64'h0000_0000_0000_ffff;
      end
      2'd2: begin
        strb_base = 8'h0f;
        load_mask = 64'h0000_0000_ffff_ffff;
      end
      default: begin
        strb_base = 8'hff;
        load_mask = 64'hffff_ffff_ffff_ffff;
      end
    endcase
  end

  // Right-justify the addressed bytes of the returned beat.
  assign load_data = (bus_rdata_i >> {offset, 3'b000}) & load_mask;

  // State and datapath registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= StIdle;
      write_q    <= 1'b0;
      size_q     <= 2'd0;
      addr_q     <= '0;
      wdata_q    <= '0;
      cnt_q      <= '0;
      rdata_q    <= '0;
      rerr_q     <= 1'b0;
      err_q      <= 1'b0;
      err_addr_q <= '0;
    end else begin
      state_q    <= state_d;
      write_q    <= write_d;
      size_q     <= size_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      cnt_q      <= cnt_d;
      rdata_q    <= rdata_d;
      rerr_q     <= rerr_d;
      err_q      <= err_d;
      err_addr_q <= err_addr_d;
    end
  end

  // Next-state logic: request accept, bus handshake, response wait and upstream return.
  always_comb begin
    state_d    = state_q;
    write_d    = write_q;
    size_d     = size_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    cnt_d      = cnt_q;
    rdata_d    = rdata_q;
    rerr_d     = rerr_q;
    err_d      = 1'b0;
    err_addr_d = err_addr_q;

    unique case (state_q)
      StIdle: begin
        if (req_vld_i) begin
          write_d = req_write_i;
          size_d  = req_size_i[1:0];
          addr_d  = req_addr_i;
          wdata_d = req_wdata_i;
          if (misaligned) begin
            if (req_write_i) begin
              // Stores have no upstream response, so the fault goes to the error port.
              err_d      = 1'b1;
              err_addr_d = req_addr_i;
              state_d    = StIdle;
            end else begin
              rdata_d = '0;
              rerr_d  = 1'b1;
              state_d = StUpresp;
            end
          end else begin
            state_d = StBreq;
          end
        end
      end

      StBreq: begin
        if (bus_req_rdy_i) begin
          cnt_d   = '0;
          state_d = StBresp;
        end
      end

      StBresp: begin
        cnt_d = cnt_inc[7:0];
        // A matching response takes priority over a timeout in the same cycle.
        if (!write_q && bus_rvld_i) begin
          rdata_d = load_data;
          rerr_d  = 1'b0;
          state_d = StUpresp;
        end else if (write_q && bus_bvld_i) begin
          state_d = StIdle;
        end else if (timeout) begin
          if (write_q) begin
            err_d      = 1'b1;
            err_addr_d = addr_q;
            state_d    = StIdle;
          end else begin
            rdata_d = '0;
            rerr_d  = 1'b1;
            state_d = StUpresp;
          end
        end
      end

      StUpresp: begin
        if (resp_rdy_i) begin
          state_d = StIdle;
        end
      end

      default: state_d = StIdle;
    endcase
  end

  // Outputs are decoded from registered state only.
  always_comb begin
    req_rdy_o     = (state_q == StIdle) && !rst;
    resp_vld_o    = (state_q == StUpresp);
    resp_data_o   = rdata_q;
    resp_err_o    = (state_q == StUpresp) && rerr_q;
    bus_req_vld_o = (state_q == StBreq);
    bus_we_o      = (state_q == StBreq) && write_q;
    bus_addr_o    = {addr_q[63:3], 3'b000};
    bus_wdata_o   = wdata_q << {offset, 3'b000};
    bus_wstrb_o   = ((state_q == StBreq) && write_q) ? 8'(strb_base << offset) : 8'h00;
    err_o         = err_q;
    err_addr_o    = err_addr_q;
  end

endmodule

// File: doc/uncache_mem_bridge.md
UNCACHE_MEM_BRIDGE -- requirements
Module: uncache_mem_bridge

Interface
REQ-001 SHALL have parameter: TIMEOUT_CYCLES, default 255, max cycles waited in BRESP before error (8-bit counter).
REQ-002 SHALL have port: clk  input  1  sole clock, all logic on rising edge.
REQ-003 SHALL have port: rst  input  1  synchronous, active-high reset.
REQ-004 SHALL have ports from LSU: req_vld_i in 1; req_rdy_o out 1; req_write_i in 1; req_size_i in 3 (bits[1:0] used: 0=B, 1=H, 2=W, 3=D; bit 2 ignored); req_addr_i in 64; req_wdata_i in 64 (right-justified).
REQ-005 SHALL have ports to LSU: resp_vld_o out 1; resp_rdy_i in 1; resp_data_o out 64 (right-justified, zero-extended); resp_err_o out 1.
REQ-006 SHALL have bus ports: bus_req_vld_o out 1; bus_req_rdy_i in 1; bus_we_o out 1; bus_addr_o out 64 (8-byte aligned); bus_wdata_o out 64; bus_wstrb_o out 8; bus_rvld_i in 1; bus_rdata_i in 64; bus_bvld_i in 1 (write ack).
REQ-007 SHALL have error ports: err_o out 1 (one-cycle pulse); err_addr_o out 64.

Function
REQ-008 SHALL implement FSM states IDLE, BREQ, BRESP, UPRESP; one transaction outstanding.
REQ-009 req_rdy_o SHALL be 1 only in IDLE; accept when req_vld_i && req_rdy_o; latch write, size[1:0], addr, wdata.
REQ-010 Misalignment SHALL be: H with addr[0]!=0; W with addr[1:0]!=0; D with addr[2:0]!=0.
REQ-011 On accepted misaligned load: no bus access, next state UPRESP with resp_err_o=1, resp_data_o=0.
REQ-012 On accepted misaligned store: no bus access, err_o=1 and err_addr_o=addr next cycle, return to IDLE; no upstream response.
REQ-013 On accepted aligned request: next state BREQ.
REQ-014 In BREQ: bus_req_vld_o=1, bus_we_o=write, bus_addr_o={addr[63:3],3'b0}; stable until bus_req_rdy_i; on handshake go BRESP, clear timeout counter.
REQ-015 bus_wstrb_o SHALL be (B 0x01, H 0x03, W 0x0F, D 0xFF) << addr[2:0]; bus_wdata_o = wdata << (8*addr[2:0]); bus_wstrb_o=0 for loads.
REQ-016 In BRESP for load: on bus_rvld_i capture (bus_rdata_i >> 8*addr[2:0]) masked to size, zero-extended; go UPRESP, resp_err_o=0.
REQ-017 In BRESP for store: on bus_bvld_i go IDLE; stores never generate resp_vld_o.
REQ-018 Timeout counter SHALL increment each BRESP cycle; when it equals TIMEOUT_CYCLES without response: load -> UPRESP, data 0, resp_err_o=1; store -> IDLE, err_o pulse with err_addr_o=addr.
REQ-019 Response arriving in same cycle as timeout SHALL win (normal completion, no error).
REQ-020 In UPRESP: resp_vld_o=1, data/err stable until resp_rdy_i; on handshake go IDLE; req_rdy_o asserts next cycle (no same-cycle reuse).
REQ-021 bus_rvld_i/bus_bvld_i outside BRESP, or of wrong type (rvld on store, bvld on load), SHALL be ignored.
REQ-022 Minimum latency: aligned load with bus_req_rdy_i=1 and bus_rvld_i one cycle after handshake -> resp_vld_o 3 cycles after request accept.

Reset
REQ-023 On rst=1 at clk edge: state IDLE, counter 0, captured data 0, err_o=0, err_addr_o=0.
REQ-024 During/after reset: req_rdy_o=0 while rst=1, then 1; resp_vld_o, bus_req_vld_o, bus_wstrb_o, resp_err_o all 0.
REQ-025 Reset mid-transaction SHALL drop it silently; later bus responses ignored per REQ-021.

Verification
REQ-026 Load H, addr 0x8000_0006, bus_rdata 0x1122_3344_5566_7788 -> bus_addr 0x8000_0000, wstrb 0, resp_data 0x1122, resp_err 0.
REQ-027 Store B, addr 0x8000_0003, wdata 0xAB -> bus_wstrb 0x08, bus_wdata 0x0000_0000_AB00_0000; bvld -> IDLE, no resp_vld_o.
REQ-028 Load W, addr 0x8000_0002 -> no bus_req_vld_o, resp_vld_o with resp_err 1, data 0; store D addr 0x...4 -> err_o pulse, err_addr 0x...4.
REQ-029 TIMEOUT_CYCLES=4, load, bus never responds -> resp_vld_o err 1 after 4 BRESP cycles; repeat with rvld on 4th cycle -> no error.
REQ-030 Hold resp_rdy_i=0 for 5 cycles, bus_req_rdy_i low 3 cycles -> outputs stable, req_rdy_o 0 throughout; assert rst mid-BRESP -> IDLE, late rvld ignored.
